buff_nn_to_ip: RTL and testbench
================================

Name: buff_nn_to_ip

Overview:
Return-path buffer between the neural-network core and the UDP transmit path. It collects the NN's per-class output scores and latches the requester's addressing. It computes the winning class (argmax) and then streams a fixed-length reply payload byte-by-byte to the UDP/IP transmitter over a valid/ready handshake. It is the mirror of the RX-side image buffer: the NN writes into it, and the network side reads out of it.

Parameters:
NUM_CLASSES, 10, number of score words accepted from the NN (index 0..NUM_CLASSES-1)
SCORE_BYTES, 3, bytes per score on the wire (18-bit score sign-extended to 24 bits)

Ports:
ACLK  in  1  clock, all logic rising-edge
ARESET  in  1  synchronous reset, active-low (0 = reset)
NN_DATA  in  18  signed score from NN
NN_ADDR  in  4  class index for NN_DATA
NN_EN  in  1  score write strobe
NN_DONE  in  1  single-cycle pulse: all scores written, start reply
SRC_IP_ADDRESS_NN  in  [0:31]  requester IP
SRC_MAC_ADDRESS_NN  in  [0:47]  requester MAC
SRC_UDP_PORT_NN  in  [0:15]  requester UDP port
NN_BUSY  out  1  high while the reply is in progress; NN writes are ignored
DST_IP_ADDRESS_IP  out  [0:31]  latched destination IP for the TX header
DST_MAC_ADDRESS_IP  out  [0:48-1]  latched destination MAC
DST_UDP_PORT_IP  out  [0:15]  latched destination port
TX_DATA  out  8  payload byte
TX_VALID  out  1  TX_DATA valid
TX_READY  in  1  transmitter accepts the byte when TX_VALID && TX_READY
TX_LAST  out  1  high with the final payload byte
TX_DONE  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (ARESET sampled 0 at an edge):
  - State goes to IDLE.
  - All outputs go to 0: TX_DATA, TX_VALID, TX_LAST, TX_DONE, NN_BUSY, and DST_* all zero.
  - The score RAM/registers clear to 0.
  - Reset asserted mid-stream aborts the reply immediately; no TX_DONE is produced.
- States:
  - IDLE: NN_BUSY=0.
    - NN_EN=1 with NN_ADDR<NUM_CLASSES writes score[NN_ADDR]. NN_ADDR>=NUM_CLASSES is ignored.
    - On NN_DONE=1: latch SRC_*_NN into DST_*_IP, then go to ARGMAX.
    - If NN_EN and NN_DONE are both high in the same cycle, that write is committed before the scan.
  - ARGMAX: NN_BUSY=1. Scans indices 0..NUM_CLASSES-1, one per cycle (NUM_CLASSES cycles), keeping the running max with a signed compare. Ties keep the lowest index. Then goes to SEND.
  - SEND: NN_BUSY=1, TX_VALID=1.
    - Payload length is P = 1 + NUM_CLASSES*SCORE_BYTES (31 by default).
    - Byte 0 is the argmax index, zero-extended.
    - Bytes 1.. carry score[0..NUM_CLASSES-1] in order. Each score is sign-extended to 24 bits and sent MSB byte first.
    - The byte index advances only on a handshake.
    - TX_DATA and TX_LAST hold stable while TX_VALID && !TX_READY.
    - TX_LAST=1 exactly when byte index = P-1.
    - When the final byte is accepted, go to DONE.
  - DONE: TX_DONE=1 and NN_BUSY=1 for one cycle. TX_VALID=0. Then go to IDLE.
- Latency:
  - NN_DONE sampled at edge t puts TX_VALID=1 at edge t+NUM_CLASSES+1.
  - With TX_READY held at 1, TX_DONE is high in the cycle after TX_LAST is accepted.
  - Total latency from NN_DONE to TX_DONE is NUM_CLASSES+P+1 cycles.
- Ignored inputs:
  - NN_DONE outside IDLE is ignored (no queuing).
  - NN_EN outside IDLE is ignored, so scores stay frozen during the reply.
- Score retention:
  - Scores not rewritten between replies keep their previous values.
  - DST_* hold their values until the next accepted NN_DONE.
- No combinational path from TX_READY to TX_VALID, and none from NN inputs to TX outputs.

Test Plan:
1. Reset: hold ARESET=0 for 3 cycles with NN_DONE=1 -> all outputs 0, no TX_VALID; after release, state is IDLE.
2. Basic reply:
   - Stimulus: write scores 0..9 = {5,-3,100,7,100,0,-131072,131071,2,1}; IP=0x0A000001, port 0x1234; NN_DONE; TX_READY=1.
   - Required: TX_VALID rises 11 cycles after NN_DONE.
   - Required bytes: 0x07 (index 7 wins with 131071), then 00 00 05, FF FF FD, 00 00 64, ...; score 6 = FE 00 00; score 7 = 01 FF FF.
   - Required: TX_LAST on byte 30; TX_DONE one cycle later; DST_IP=0x0A000001.
3. Tie and negative scores: all scores = -1 except index 3 and index 8 = 50 -> byte 0 = 0x03.
4. Backpressure: toggle TX_READY 1,0,0,1,... -> bytes appear once each in order with no loss or duplication; TX_DATA is stable while stalled; TX_LAST is held while stalled.
5. Busy protection:
   - Stimulus: during SEND, pulse NN_EN (addr 2, data 9) and NN_DONE.
   - Required: the current stream is unchanged; no second reply is produced.
   - Required: a subsequent NN_DONE in IDLE replays score[2]=100 (not 9).
6. Reset mid-stream: assert ARESET=0 at byte 12 -> TX_VALID=0 next edge, no TX_DONE; a new NN_DONE afterwards sends all-zero scores with byte 0 = 0x00.

Source files
------------

// File: rtl/buff_nn_to_ip.sv
// buff_nn_to_ip: return-path buffer between the NN core and the UDP transmitter.
// Collects per-class scores, latches the requester's addressing, finds the
// winning class and streams a fixed-length reply payload over valid/ready.
module buff_nn_to_ip #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_BYTES = 3
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [17:0] NN_DATA,
  input  logic [3:0]  NN_ADDR,
  input  logic        NN_EN,
  input  logic        NN_DONE,
  input  logic [0:31] SRC_IP_ADDRESS_NN,
  input  logic [0:47] SRC_MAC_ADDRESS_NN,
  input  logic [0:15] SRC_UDP_PORT_NN,
  output logic        NN_BUSY,
  output logic [0:31] DST_IP_ADDRESS_IP,
  output logic [0:47] DST_MAC_ADDRESS_IP,
  output logic [0:15] DST_UDP_PORT_IP,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        TX_LAST,
  output logic        TX_DONE
);

  localparam int PAYLOAD_LEN = 1 + NUM_CLASSES * SCORE_BYTES;
  localparam int IDX_W       = $clog2(NUM_CLASSES);
  localparam int SCAN_W      = $clog2(NUM_CLASSES + 1);
  localparam int BYTE_W      = $clog2(PAYLOAD_LEN);
  localparam int PART_W      = (SCORE_BYTES > 1) ? $clog2(SCORE_BYTES) : 1;
  localparam int WIRE_W      = SCORE_BYTES * 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARGMAX,
    S_SEND,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [17:0]         score_q [NUM_CLASSES];
  logic [17:0]         score_d [NUM_CLASSES];
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [17:0]         best_val_q, best_val_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
  logic [IDX_W-1:0]    cls_q, cls_d;
  logic [PART_W-1:0]   part_q, part_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                tx_last_q, tx_last_d;
  logic                tx_done_q, tx_done_d;
  logic                busy_q, busy_d;
  logic [0:31]         dst_ip_q, dst_ip_d;
  logic [0:47]         dst_mac_q, dst_mac_d;
  logic [0:15]         dst_port_q, dst_port_d;

  logic [IDX_W-1:0]    scan_idx;
  logic [IDX_W-1:0]    nxt_cls;
  logic [PART_W-1:0]   nxt_part;

  assign scan_idx = scan_q[IDX_W-1:0];

  // Wire-order byte of a score: sign-extended to the wire width, MSB byte first.
  function automatic logic [7:0] score_byte(input logic [17:0] s, input logic [PART_W-1:0] part);
    logic [WIRE_W-1:0] wide;
    wide = {{(WIRE_W - 18){s[17]}}, s};
    return wide[(SCORE_BYTES - 1 - int'(part)) * 8 +: 8];
  endfunction

  // Next-state logic: score capture, argmax scan and the byte streamer.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    scan_d     = scan_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    byte_idx_d = byte_idx_q;
    cls_d      = cls_q;
    part_d     = part_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    tx_done_d  = 1'b0;
    busy_d     = busy_q;
    dst_ip_d   = dst_ip_q;
    dst_mac_d  = dst_mac_q;
    dst_port_d = dst_port_q;
    nxt_cls    = cls_q;
    nxt_part   = part_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (NN_EN && ({28'b0, NN_ADDR} < 32'(NUM_CLASSES))) begin
          score_d[NN_ADDR[IDX_W-1:0]] = NN_DATA;
        end
        if (NN_DONE) begin
          dst_ip_d   = SRC_IP_ADDRESS_NN;
          dst_mac_d  = SRC_MAC_ADDRESS_NN;
          dst_port_d = SRC_UDP_PORT_NN;
          scan_d     = '0;
          busy_d     = 1'b1;
          state_d    = S_ARGMAX;
        end
      end

      S_ARGMAX: begin
        if (scan_q == SCAN_W'(NUM_CLASSES)) begin
          tx_valid_d = 1'b1;
          tx_data_d  = 8'(best_idx_q);
          tx_last_d  = 1'b0;
          byte_idx_d = '0;
          cls_d      = '0;
          part_d     = '0;
          state_d    = S_SEND;
        end else begin
          if ((scan_q == '0) || ($signed(score_q[scan_idx]) > $signed(best_val_q))) begin
            best_val_d = score_q[scan_idx];
            best_idx_d = scan_idx;
          end
          scan_d = scan_q + SCAN_W'(1);
        end
      end

      S_SEND: begin
        if (TX_READY) begin
          if (tx_last_q) begin
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            tx_done_d  = 1'b1;
            state_d    = S_DONE;
          end else begin
            if (byte_idx_q == '0) begin
              nxt_cls  = '0;
              nxt_part = '0;
            end else if (part_q == PART_W'(SCORE_BYTES - 1)) begin
              nxt_cls  = cls_q + IDX_W'(1);
              nxt_part = '0;
            end else begin
              nxt_part = part_q + PART_W'(1);
            end
            cls_d      = nxt_cls;
            part_d     = nxt_part;
            byte_idx_d = byte_idx_q + BYTE_W'(1);
            tx_data_d  = score_byte(score_q[nxt_cls], nxt_part);
            tx_last_d  = ((byte_idx_q + BYTE_W'(1)) == BYTE_W'(PAYLOAD_LEN - 1));
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        score_q[i] <= '0;
      end
      scan_q     <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      byte_idx_q <= '0;
      cls_q      <= '0;
      part_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
      dst_ip_q   <= '0;
      dst_mac_q  <= '0;
      dst_port_q <= '0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      scan_q     <= scan_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      byte_idx_q <= byte_idx_d;
      cls_q      <= cls_d;
      part_q     <= part_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      tx_done_q  <= tx_done_d;
      busy_q     <= busy_d;
      dst_ip_q   <= dst_ip_d;
      dst_mac_q  <= dst_mac_d;
      dst_port_q <= dst_port_d;
    end
  end

  assign NN_BUSY            = busy_q;
  assign DST_IP_ADDRESS_IP  = dst_ip_q;
  assign DST_MAC_ADDRESS_IP = dst_mac_q;
  assign DST_UDP_PORT_IP    = dst_port_q;
  assign TX_DATA            = tx_data_q;
  assign TX_VALID           = tx_valid_q;
  assign TX_LAST            = tx_last_q;
  assign TX_DONE            = tx_done_q;

endmodule

// File: tb/tb_buff_nn_to_ip.sv
// tb_buff_nn_to_ip: table-driven and randomized bench for buff_nn_to_ip with a
// payload reference model built from the reply format rules.
module tb_buff_nn_to_ip;

  localparam int NCLS = 10;
  localparam int PLEN = 1 + NCLS * 3;

  logic        ACLK;
  logic        ARESET;
  logic [17:0] NN_DATA;
  logic [3:0]  NN_ADDR;
  logic        NN_EN;
  logic        NN_DONE;
  logic [0:31] SRC_IP_ADDRESS_NN;
  logic [0:47] SRC_MAC_ADDRESS_NN;
  logic [0:15] SRC_UDP_PORT_NN;
  logic        NN_BUSY;
  logic [0:31] DST_IP_ADDRESS_IP;
  logic [0:47] DST_MAC_ADDRESS_IP;
  logic [0:15] DST_UDP_PORT_IP;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        TX_LAST;
  logic        TX_DONE;

  buff_nn_to_ip dut (
    .ACLK               (ACLK),
    .ARESET             (ARESET),
    .NN_DATA            (NN_DATA),
    .NN_ADDR            (NN_ADDR),
    .NN_EN              (NN_EN),
    .NN_DONE            (NN_DONE),
    .SRC_IP_ADDRESS_NN  (SRC_IP_ADDRESS_NN),
    .SRC_MAC_ADDRESS_NN (SRC_MAC_ADDRESS_NN),
    .SRC_UDP_PORT_NN    (SRC_UDP_PORT_NN),
    .NN_BUSY            (NN_BUSY),
    .DST_IP_ADDRESS_IP  (DST_IP_ADDRESS_IP),
    .DST_MAC_ADDRESS_IP (DST_MAC_ADDRESS_IP),
    .DST_UDP_PORT_IP    (DST_UDP_PORT_IP),
    .TX_DATA            (TX_DATA),
    .TX_VALID           (TX_VALID),
    .TX_READY           (TX_READY),
    .TX_LAST            (TX_LAST),
    .TX_DONE            (TX_DONE)
  );

  typedef struct {
    logic [9:0]        wmask;
    logic [9:0][17:0]  scores;
    logic [31:0]       ip;
    logic [47:0]       mac;
    logic [15:0]       port;
    int                mode;
    int                injectAt;
    int                abortAt;
    bit                doneWr;
    logic [3:0]        doneWrAddr;
    logic [17:0]       doneWrData;
    int                expIdx;
  } testVec_t;

  int          checks;
  int          errors;
  int          mScore [NCLS];
  logic [31:0] mIp;
  logic [47:0] mMac;
  logic [15:0] mPort;
  testVec_t    vecs [8];

  // 100 MHz clock
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Global watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle score write; model follows the write-enable address rule
  task automatic applyStimulus(input logic [3:0] addr, input logic [17:0] data);
    NN_EN   = 1'b1;
    NN_ADDR = addr;
    NN_DATA = data;
    if (addr < NCLS) mScore[addr] = int'($signed(data));
    @(posedge ACLK); #1;
    NN_EN = 1'b0;
  endtask

  function automatic int modelArgmax();
    int best;
    best = 0;
    for (int i = 1; i < NCLS; i++) if (mScore[i] > mScore[best]) best = i;
    return best;
  endfunction

  // Fire NN_DONE and follow the reply to completion (or to a reset abort)
  task automatic runReply(input int mode, input int injectAt, input int abortAt,
                          input bit doneWr, input logic [3:0] doneWrAddr,
                          input logic [17:0] doneWrData, output logic [7:0] dutArg);
    logic [7:0] expQ [$];
    int   k;
    int   idx;
    bit   acc;
    bit   injected;
    bit   seenValid;
    bit   finished;
    bit   prevStall;
    bit   sawIdle;
    logic [7:0] prevData;
    logic prevLast;
    int   v;

    dutArg = 8'hxx;
    NN_DONE = 1'b1;
    NN_EN   = doneWr;
    NN_ADDR = doneWrAddr;
    NN_DATA = doneWrData;
    if (doneWr && doneWrAddr < NCLS) mScore[doneWrAddr] = int'($signed(doneWrData));
    mIp   = SRC_IP_ADDRESS_NN;
    mMac  = SRC_MAC_ADDRESS_NN;
    mPort = SRC_UDP_PORT_NN;

    expQ.delete();
    expQ.push_back(8'(modelArgmax()));
    for (int j = 0; j < NCLS; j++) begin
      for (int b = 0; b < 3; b++) begin
        v = (mScore[j] >> (8 * (2 - b))) & 255;
        expQ.push_back(8'(v));
      end
    end

    @(posedge ACLK); #1;
    NN_DONE = 1'b0;
    NN_EN   = 1'b0;
    checkOutput("busy_on_start", NN_BUSY, 1);

    k = 0; idx = 0; acc = 0; injected = 0; seenValid = 0; finished = 0;
    prevStall = 0; prevData = '0; prevLast = 0;
    while (!finished) begin
      @(posedge ACLK); #1;
      k++;
      if (acc) idx++;
      acc = 0;
      NN_EN   = 1'b0;
      NN_DONE = 1'b0;

      if (!seenValid && TX_VALID) begin
        seenValid = 1;
        checkOutput("valid_latency", k, NCLS + 1);
      end

      if (TX_VALID) begin
        if (idx == 0) dutArg = TX_DATA;
        if (idx < PLEN) begin
          checkOutput($sformatf("byte%0d", idx), TX_DATA, expQ[idx]);
          checkOutput($sformatf("last%0d", idx), TX_LAST, (idx == PLEN - 1));
        end else begin
          checkOutput("extra_byte", idx, PLEN - 1);
        end
        if (prevStall) begin
          checkOutput("stall_data_stable", TX_DATA, prevData);
          checkOutput("stall_last_stable", TX_LAST, prevLast);
        end
      end

      if (TX_DONE) begin
        checkOutput("done_after_last", idx, PLEN);
        checkOutput("done_valid_low", TX_VALID, 0);
        checkOutput("done_busy", NN_BUSY, 1);
        if (mode == 0) checkOutput("done_latency", k, NCLS + PLEN + 1);
        finished = 1;
      end else if (abortAt >= 0 && TX_VALID && idx == abortAt) begin
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        checkOutput("abort_valid", TX_VALID, 0);
        checkOutput("abort_done", TX_DONE, 0);
        checkOutput("abort_busy", NN_BUSY, 0);
        checkOutput("abort_dst_ip", DST_IP_ADDRESS_IP, 0);
        ARESET = 1'b1;
        for (int i = 0; i < NCLS; i++) mScore[i] = 0;
        mIp = '0; mMac = '0; mPort = '0;
        sawIdle = 0;
        for (int c = 0; c < 6; c++) begin
          @(posedge ACLK); #1;
          if (TX_DONE || TX_VALID) sawIdle = 1;
        end
        checkOutput("abort_no_done", sawIdle, 0);
        return;
      end else begin
        if (injectAt >= 0 && TX_VALID && idx == injectAt && !injected) begin
          NN_EN   = 1'b1;
          NN_ADDR = 4'd2;
          NN_DATA = 18'd9;
          NN_DONE = 1'b1;
          injected = 1;
        end
        case (mode)
          0:       TX_READY = 1'b1;
          1:       TX_READY = (k % 4 == 0) || (k % 4 == 3);
          default: TX_READY = 1'($urandom_range(0, 1));
        endcase
        prevStall = TX_VALID && !TX_READY;
        prevData  = TX_DATA;
        prevLast  = TX_LAST;
        acc       = TX_VALID && TX_READY;
      end

      if (k > 600) begin
        checkOutput("reply_timeout", k, 0);
        finished = 1;
      end
    end

    // Back in IDLE with addressing held and no spurious second reply
    sawIdle = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge ACLK); #1;
      NN_EN = 1'b0; NN_DONE = 1'b0;
      if (TX_VALID || TX_DONE || NN_BUSY) sawIdle = 1;
    end
    checkOutput("idle_after_reply", sawIdle, 0);
    checkOutput("dst_ip", DST_IP_ADDRESS_IP, mIp);
    checkOutput("dst_mac", DST_MAC_ADDRESS_IP, mMac);
    checkOutput("dst_port", DST_UDP_PORT_IP, mPort);
  endtask

  initial begin : main
    int basic [NCLS];
    int tie [NCLS];
    logic [7:0] dutArg;

    checks = 0;
    errors = 0;
    basic = '{5, -3, 100, 7, 100, 0, -131072, 131071, 2, 1};
    tie   = '{-1, -1, -1, 50, -1, -1, -1, -1, 50, -1};
    for (int i = 0; i < NCLS; i++) mScore[i] = 0;
    mIp = '0; mMac = '0; mPort = '0;

    // Vector table: basic, busy protection, replay, tie, backpressure,
    // concurrent write with NN_DONE, mid-stream reset, post-reset reply
    for (int t = 0; t < 8; t++) begin
      vecs[t].wmask = '0;
      vecs[t].scores = '0;
      vecs[t].ip = 32'h0A000001;
      vecs[t].mac = 48'h0011_2233_4455 + 48'(t);
      vecs[t].port = 16'h1234 + 16'(t);
      vecs[t].mode = 0;
      vecs[t].injectAt = -1;
      vecs[t].abortAt = -1;
      vecs[t].doneWr = 0;
      vecs[t].doneWrAddr = '0;
      vecs[t].doneWrData = '0;
      vecs[t].expIdx = 0;
    end
    vecs[0].wmask = 10'h3FF;
    for (int i = 0; i < NCLS; i++) vecs[0].scores[i] = 18'(basic[i]);
    vecs[0].expIdx = 7;
    vecs[1].injectAt = 5; vecs[1].expIdx = 7; vecs[1].ip = 32'hC0A80105;
    vecs[2].expIdx = 7; vecs[2].ip = 32'hC0A80106;
    vecs[3].wmask = 10'h3FF;
    for (int i = 0; i < NCLS; i++) vecs[3].scores[i] = 18'(tie[i]);
    vecs[3].expIdx = 3;
    vecs[4].mode = 1; vecs[4].expIdx = 3;
    vecs[5].mode = 2; vecs[5].doneWr = 1; vecs[5].doneWrAddr = 4'd5;
    vecs[5].doneWrData = 18'(131071); vecs[5].expIdx = 5;
    vecs[6].abortAt = 12; vecs[6].expIdx = 5;
    vecs[7].expIdx = 0; vecs[7].ip = 32'h0A0000FE;

    ARESET = 1'b0; NN_DATA = '0; NN_ADDR = '0; NN_EN = 1'b0; NN_DONE = 1'b1;
    SRC_IP_ADDRESS_NN = 32'hDEADBEEF; SRC_MAC_ADDRESS_NN = 48'hFFFF_FFFF_FFFF;
    SRC_UDP_PORT_NN = 16'hFFFF; TX_READY = 1'b0;

    $display("[TB] reset with NN_DONE held high");
    for (int c = 0; c < 3; c++) begin
      @(posedge ACLK); #1;
      checkOutput("rst_valid", TX_VALID, 0);
    end
    checkOutput("rst_data", TX_DATA, 0);
    checkOutput("rst_last", TX_LAST, 0);
    checkOutput("rst_done", TX_DONE, 0);
    checkOutput("rst_busy", NN_BUSY, 0);
    checkOutput("rst_dst_ip", DST_IP_ADDRESS_IP, 0);
    checkOutput("rst_dst_mac", DST_MAC_ADDRESS_IP, 0);
    checkOutput("rst_dst_port", DST_UDP_PORT_IP, 0);
    ARESET = 1'b1; NN_DONE = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("idle_busy", NN_BUSY, 0);
    checkOutput("idle_valid", TX_VALID, 0);

    for (int t = 0; t < 8; t++) begin
      $display("[TB] vector %0d", t);
      for (int i = 0; i < NCLS; i++) if (vecs[t].wmask[i]) applyStimulus(4'(i), vecs[t].scores[i]);
      applyStimulus(4'd12, 18'h2AAAA);
      SRC_IP_ADDRESS_NN  = vecs[t].ip;
      SRC_MAC_ADDRESS_NN = vecs[t].mac;
      SRC_UDP_PORT_NN    = vecs[t].port;
      runReply(vecs[t].mode, vecs[t].injectAt, vecs[t].abortAt, vecs[t].doneWr,
               vecs[t].doneWrAddr, vecs[t].doneWrData, dutArg);
      checkOutput($sformatf("argmax_vec%0d", t), dutArg, 8'(vecs[t].expIdx));
    end

    $display("[TB] randomized replies");
    for (int r = 0; r < 5; r++) begin
      logic [9:0] mask;
      mask = 10'($urandom);
      for (int i = 0; i < NCLS; i++) if (mask[i]) applyStimulus(4'(i), 18'($urandom));
      applyStimulus(4'($urandom_range(10, 15)), 18'($urandom));
      SRC_IP_ADDRESS_NN  = $urandom;
      SRC_MAC_ADDRESS_NN = {16'($urandom), 32'($urandom)};
      SRC_UDP_PORT_NN    = 16'($urandom);
      runReply(r % 3, -1, -1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               18'($urandom), dutArg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
